// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared widths, ROM word field positions and state encoding for song_reader
package song_pkg;
    localparam int ADDR_W = 7;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY
    } state_t;

    // Bit 15 and bits 2:0 of the ROM word carry nothing the player uses.
    function automatic logic [NOTE_W-1:0] get_note(input logic [15:0] word);
        return word[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [DUR_W-1:0] get_dur(input logic [15:0] word);
        return word[DUR_MSB:DUR_LSB];
    endfunction
endpackage

// File: rtl/note_timer.sv
// rtl/note_timer.sv - beat-driven duration counter; expire fires on the beat that ends the note
module note_timer
    import song_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] dur,
    input  logic             beat,
    input  logic             en,
    output logic             expire
);
    logic [DUR_W-1:0] r_count;

    // load wins over beat, so a beat coinciding with the load is not charged to the new note
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= dur;
        end else if (en && beat && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expire = en && beat && (r_count == {{(DUR_W-1){1'b0}}, 1'b1});
endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - ROM-driven note sequencer; SONG_READER_LOOP_EN restarts the song while play is held
module song_reader
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [NOTE_W-1:0] note,
    output logic              new_note,
    output logic              playing,
    output logic              song_done
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [NOTE_W-1:0] r_note;
    logic              r_new_note;
    logic              r_playing;
    logic              r_song_done;

    logic [NOTE_W-1:0] w_rom_note;
    logic [DUR_W-1:0]  w_rom_dur;
    logic              w_load;
    logic              w_en;
    logic              w_expire;
    logic              w_end;
    logic              w_restart;

    assign w_rom_note = get_note(rom_data);
    assign w_rom_dur  = get_dur(rom_data);
    assign w_load     = (r_state == WAIT) && (w_rom_dur != '0);
    assign w_en       = (r_state == PLAY) && play;
    // End of song: a zero-duration terminator, or running off the top of the ROM
    assign w_end      = ((r_state == WAIT) && (w_rom_dur == '0)) ||
                        (w_expire && (r_addr == ADDR_LAST));

`ifdef SONG_READER_LOOP_EN
    assign w_restart = play;
`else
    assign w_restart = 1'b0;
`endif

    note_timer u_note_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .dur    (w_rom_dur),
        .beat   (beat),
        .en     (w_en),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_note      <= '0;
            r_new_note  <= 1'b0;
            r_playing   <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
            if (w_end) begin
                r_song_done <= 1'b1;
                r_note      <= '0;
                r_addr      <= '0;
                r_state     <= w_restart ? FETCH : IDLE;
                r_playing   <= w_restart;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (play) begin
                            r_state   <= FETCH;
                            r_playing <= 1'b1;
                        end
                    end
                    FETCH: begin
                        r_state <= WAIT;
                    end
                    WAIT: begin
                        r_note     <= w_rom_note;
                        r_new_note <= 1'b1;
                        r_state    <= PLAY;
                    end
                    PLAY: begin
                        if (w_expire) begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= FETCH;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_playing <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = r_addr;
    assign note      = r_note;
    assign new_note  = r_new_note;
    assign playing   = r_playing;
    assign song_done = r_song_done;
endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - directed self-checking bench for song_reader with a registered-output ROM model
module tb_song_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        beat = 1'b0;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [5:0]  note;
    logic        new_note;
    logic        playing;
    logic        song_done;

    logic [15:0] rom [128];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   beat_cnt = 0;
    int   adv_beats = -1;
    int   nn_cnt = 0;
    int   done_cnt = 0;
    bit   in_play = 1'b0;
    bit   beat_en = 1'b0;
    bit   ok;
    logic [5:0] nn_note = '0;
    logic [6:0] prev_addr = '0;
    logic [6:0] addr_before_done = '0;
    int   snap;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .beat      (beat),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note      (note),
        .new_note  (new_note),
        .playing   (playing),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [5:0] n, input logic [5:0] d);
        return {1'b0, n, d, 3'b000};
    endfunction

    // One clock: drive beat, let the edge pass, then observe outputs 1 time unit later.
    task automatic step();
        beat = beat_en && ((cyc % 4) == 1);
        if (beat && play && in_play) beat_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (song_done) begin
            done_cnt++;
            addr_before_done = prev_addr;
            if (in_play) adv_beats = beat_cnt;
            in_play = 1'b0;
        end else if (in_play && (rom_addr != prev_addr)) begin
            adv_beats = beat_cnt;
            in_play = 1'b0;
        end
        if (new_note) begin
            nn_cnt++;
            nn_note = note;
            in_play = 1'b1;
            beat_cnt = 0;
        end
        prev_addr = rom_addr;
    endtask

    task automatic wait_for(input bit want_done, input int max, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            step();
            if (want_done ? song_done : new_note) hit = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        play = 1'b0;
        beat_en = 1'b0;
        step();
        step();
        reset = 1'b0;
        in_play = 1'b0;
        beat_cnt = 0;
        adv_beats = -1;
        cyc = 0;
        beat_en = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        // Basic song: 49 for 12 beats, 1 for 8 beats, terminator
        clear_rom();
        rom[0] = mk(6'd49, 6'd12);
        rom[1] = mk(6'd1, 6'd8);
        do_reset();
        check("rst_note", 32'(note), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_new_note", 32'(new_note), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_song_done", 32'(song_done), 32'd0);
        play = 1'b1;
        step();
        check("fetch_playing", 32'(playing), 32'd1);
        step();
        check("wait_no_new_note", 32'(new_note), 32'd0);
        step();
        check("first_new_note", 32'(new_note), 32'd1);
        check("first_note", 32'(note), 32'd49);
        wait_for(1'b0, 400, ok);
        check("second_note_seen", 32'(ok), 32'd1);
        check("second_note", 32'(nn_note), 32'd1);
        check("first_dur_beats", 32'(adv_beats), 32'd12);
        check("second_addr", 32'(rom_addr), 32'd1);
        wait_for(1'b1, 400, ok);
        check("done_seen", 32'(ok), 32'd1);
        check("second_dur_beats", 32'(adv_beats), 32'd8);
        check("done_note", 32'(note), 32'd0);
        check("done_addr", 32'(rom_addr), 32'd0);
        check("done_idle", 32'(playing), 32'd0);
        play = 1'b0;
        step();
        check("done_pulse_one_cycle", 32'(song_done), 32'd0);

        // Rest entry timed like a note
        clear_rom();
        rom[0] = mk(6'd0, 6'd34);
        rom[1] = mk(6'd7, 6'd1);
        do_reset();
        play = 1'b1;
        snap = nn_cnt;
        wait_for(1'b0, 50, ok);
        check("rest_new_note", 32'(nn_cnt - snap), 32'd1);
        check("rest_note", 32'(nn_note), 32'd0);
        wait_for(1'b0, 400, ok);
        check("rest_beats", 32'(adv_beats), 32'd34);
        check("after_rest_note", 32'(nn_note), 32'd7);
        wait_for(1'b1, 100, ok);
        check("rest_song_done", 32'(ok), 32'd1);
        play = 1'b0;

        // Pause after 3 of 12 beats
        clear_rom();
        rom[0] = mk(6'd20, 6'd12);
        rom[1] = mk(6'd21, 6'd2);
        do_reset();
        play = 1'b1;
        wait_for(1'b0, 50, ok);
        for (int i = 0; i < 100 && beat_cnt < 3; i++) step();
        play = 1'b0;
        snap = nn_cnt;
        for (int i = 0; i < 50; i++) step();
        check("pause_addr", 32'(rom_addr), 32'd0);
        check("pause_note", 32'(note), 32'd20);
        check("pause_no_refetch", 32'(nn_cnt - snap), 32'd0);
        play = 1'b1;
        wait_for(1'b0, 400, ok);
        check("resume_advance", 32'(ok), 32'd1);
        check("resume_further_beats", 32'(adv_beats - 3), 32'd9);
        check("resume_next_note", 32'(nn_note), 32'd21);

        // Reset in PLAY at address 5
        clear_rom();
        for (int i = 0; i < 10; i++) rom[i] = mk(6'(10 + i), 6'd1);
        do_reset();
        play = 1'b1;
        snap = done_cnt;
        for (int i = 0; i < 6; i++) wait_for(1'b0, 50, ok);
        check("pre_reset_addr", 32'(rom_addr), 32'd5);
        reset = 1'b1;
        step();
        check("mid_rst_note", 32'(note), 32'd0);
        check("mid_rst_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_playing", 32'(playing), 32'd0);
        check("mid_rst_new_note", 32'(new_note), 32'd0);
        check("mid_rst_song_done", 32'(song_done), 32'd0);
        play = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid_rst_no_done", 32'(done_cnt - snap), 32'd0);
        check("mid_rst_stays_idle", 32'(playing), 32'd0);

        // Full ROM of one-beat notes: advance from 127 ends the song
        for (int i = 0; i < 128; i++) rom[i] = mk(6'((i % 63) + 1), 6'd1);
        do_reset();
        play = 1'b1;
        snap = nn_cnt;
        wait_for(1'b1, 3000, ok);
        check("full_done_seen", 32'(ok), 32'd1);
        check("full_note_count", 32'(nn_cnt - snap), 32'd128);
        check("full_last_addr", 32'(addr_before_done), 32'd127);
        check("full_wrap_addr", 32'(rom_addr), 32'd0);
        check("full_last_beats", 32'(adv_beats), 32'd1);
        check("full_done_note", 32'(note), 32'd0);

`ifdef SONG_READER_LOOP_EN
        // Loop: play held, song restarts from address 0
        clear_rom();
        rom[0] = mk(6'd49, 6'd2);
        rom[1] = mk(6'd1, 6'd1);
        wait_for(1'b0, 20, ok);
        do_reset();
        play = 1'b1;
        wait_for(1'b1, 400, ok);
        check("loop_done_seen", 32'(ok), 32'd1);
        check("loop_fetch_playing", 32'(playing), 32'd1);
        check("loop_addr", 32'(rom_addr), 32'd0);
        step();
        step();
        check("loop_new_note", 32'(new_note), 32'd1);
        check("loop_first_note", 32'(note), 32'd49);
        wait_for(1'b0, 400, ok);
        check("loop_first_beats", 32'(adv_beats), 32'd2);
        check("loop_second_note", 32'(nn_note), 32'd1);
`else
        // Without looping, play held after the end restarts from address 0
        clear_rom();
        rom[0] = mk(6'd33, 6'd1);
        do_reset();
        play = 1'b1;
        wait_for(1'b1, 100, ok);
        check("noloop_done_idle", 32'(playing), 32'd0);
        step();
        check("noloop_restart_fetch", 32'(playing), 32'd1);
        step();
        step();
        check("noloop_restart_note", 32'(note), 32'd33);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
